// File: rtl/lzss_dec_expand.sv
// lzss_dec_expand: LZSS match-expansion sequencer.
// Takes literal / (offset, length) match tokens and emits one reconstructed
// byte per cycle. It owns the sliding-window history and replays matches from
// it, including copies that overlap the bytes being produced.
// Optional build macro: LZSS_DEC_EXPAND_ERRCHK_EN adds a history fill counter
// and a sticky out-of-window reference flag on o_error (tied 0 otherwise).
module lzss_dec_expand #(
   parameter int unsigned pDataWidth   = 8,
   parameter int unsigned pOffsetWidth = 6,
   parameter int unsigned pLengthWidth = 3
) (
   input  logic                    clk,
   input  logic                    rst_x,
   input  logic                    i_valid,
   output logic                    ow_ready,
   input  logic                    i_last,
   input  logic                    i_flag,
   input  logic [pDataWidth-1:0]   i_data_or_offset,
   input  logic [pLengthWidth-1:0] i_length,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic [pDataWidth-1:0]   o_data,
   output logic                    o_last,
   output logic                    o_error
);

   localparam int unsigned DEPTH  = 1 << pOffsetWidth;
   localparam int unsigned FILL_W = pOffsetWidth + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LIT  = 2'd1,
      ST_COPY = 2'd2
   } state_e;

   state_e                    state_q, state_d;
   logic [pDataWidth-1:0]     win_q [DEPTH];
   logic [pOffsetWidth-1:0]   wptr_q, wptr_d;
   logic [pOffsetWidth-1:0]   off_q, off_d;
   logic [pLengthWidth-1:0]   remain_q, remain_d;
   logic                      last_tok_q, last_tok_d;
   logic                      o_valid_q, o_valid_d;
   logic [pDataWidth-1:0]     o_data_q, o_data_d;
   logic                      o_last_q, o_last_d;

   logic                      out_ack;
   logic                      in_ack;
   logic                      stream_end;
   logic                      win_we;
   logic [pDataWidth-1:0]     win_wdata;
   logic [pOffsetWidth-1:0]   i_off;
   logic [pOffsetWidth-1:0]   rd_off;
   logic [pOffsetWidth-1:0]   rd_addr;
   logic [pDataWidth-1:0]     rd_data;
   logic [pLengthWidth-1:0]   len_eff;

   assign i_off   = i_data_or_offset[pOffsetWidth-1:0];
   assign len_eff = (i_length == '0) ? pLengthWidth'(1) : i_length;

   // Handshakes; a new token may slip in as the previous token's final byte leaves.
   always_comb begin
      out_ack    = o_valid_q & i_ready;
      ow_ready   = (state_q == ST_IDLE) |
                   (out_ack & (remain_q == '0) & ~o_last_q);
      in_ack     = i_valid & ow_ready;
      stream_end = out_ack & o_last_q;
   end

   // Window read: dist = offset + 1 bytes behind the write pointer, modulo depth.
   always_comb begin
      rd_off  = in_ack ? i_off : off_q;
      rd_addr = pOffsetWidth'(wptr_q - rd_off - pOffsetWidth'(1));
      rd_data = win_q[rd_addr];
   end

   // Next-state and output-byte generation.
   always_comb begin
      state_d    = state_q;
      wptr_d     = wptr_q;
      off_d      = off_q;
      remain_d   = remain_q;
      last_tok_d = last_tok_q;
      o_valid_d  = o_valid_q;
      o_data_d   = o_data_q;
      o_last_d   = o_last_q;
      win_we     = 1'b0;
      win_wdata  = rd_data;

      if (in_ack) begin
         o_valid_d  = 1'b1;
         win_we     = 1'b1;
         wptr_d     = pOffsetWidth'(wptr_q + pOffsetWidth'(1));
         last_tok_d = i_last;
         if (i_flag) begin
            state_d   = ST_COPY;
            off_d     = i_off;
            o_data_d  = rd_data;
            win_wdata = rd_data;
            remain_d  = pLengthWidth'(len_eff - pLengthWidth'(1));
            o_last_d  = i_last & (len_eff == pLengthWidth'(1));
         end else begin
            state_d   = ST_LIT;
            o_data_d  = i_data_or_offset;
            win_wdata = i_data_or_offset;
            remain_d  = '0;
            o_last_d  = i_last;
         end
      end else if (out_ack) begin
         if (o_last_q) begin
            state_d   = ST_IDLE;
            o_valid_d = 1'b0;
            o_last_d  = 1'b0;
            wptr_d    = '0;
            remain_d  = '0;
         end else if (remain_q != '0) begin
            o_data_d  = rd_data;
            win_we    = 1'b1;
            wptr_d    = pOffsetWidth'(wptr_q + pOffsetWidth'(1));
            remain_d  = pLengthWidth'(remain_q - pLengthWidth'(1));
            o_last_d  = last_tok_q & (remain_q == pLengthWidth'(1));
         end else begin
            state_d   = ST_IDLE;
            o_valid_d = 1'b0;
         end
      end
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge rst_x) begin
      if (!rst_x) begin
         state_q    <= ST_IDLE;
         wptr_q     <= '0;
         off_q      <= '0;
         remain_q   <= '0;
         last_tok_q <= 1'b0;
         o_valid_q  <= 1'b0;
         o_data_q   <= '0;
         o_last_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         wptr_q     <= wptr_d;
         off_q      <= off_d;
         remain_q   <= remain_d;
         last_tok_q <= last_tok_d;
         o_valid_q  <= o_valid_d;
         o_data_q   <= o_data_d;
         o_last_q   <= o_last_d;
      end
   end

   // History window; every emitted byte is written at the write pointer.
   always_ff @(posedge clk or negedge rst_x) begin
      if (!rst_x) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            win_q[i] <= '0;
         end
      end else if (win_we) begin
         win_q[wptr_q] <= win_wdata;
      end
   end

   assign o_valid = o_valid_q;
   assign o_data  = o_data_q;
   assign o_last  = o_last_q;

`ifdef LZSS_DEC_EXPAND_ERRCHK_EN
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [FILL_W-1:0] in_dist;
   logic              o_error_q, o_error_d;

   // Valid-history tracking and sticky out-of-window detection.
   always_comb begin
      in_dist   = FILL_W'(FILL_W'(i_off) + FILL_W'(1));
      fill_d    = fill_q;
      o_error_d = o_error_q;
      if (stream_end) begin
         fill_d = '0;
      end else if (win_we && (fill_q != FILL_W'(DEPTH))) begin
         fill_d = FILL_W'(fill_q + FILL_W'(1));
      end
      if (in_ack && i_flag && (in_dist > fill_q)) begin
         o_error_d = 1'b1;
      end
   end

   // Error-check registers.
   always_ff @(posedge clk or negedge rst_x) begin
      if (!rst_x) begin
         fill_q    <= '0;
         o_error_q <= 1'b0;
      end else begin
         fill_q    <= fill_d;
         o_error_q <= o_error_d;
      end
   end

   assign o_error = o_error_q;
`else
   assign o_error = 1'b0;
`endif

endmodule

// File: tb/tb_lzss_dec_expand.sv
// tb_lzss_dec_expand: directed self-checking bench for lzss_dec_expand.
// Honours LZSS_DEC_EXPAND_ERRCHK_EN to select the error-flag scenario.
module tb_lzss_dec_expand;

   logic       clk = 1'b0;
   logic       rst_x;
   logic       i_valid;
   logic       ow_ready;
   logic       i_last;
   logic       i_flag;
   logic [7:0] i_data_or_offset;
   logic [2:0] i_length;
   logic       o_valid;
   logic       i_ready;
   logic [7:0] o_data;
   logic       o_last;
   logic       o_error;

   int checks = 0;
   int errors = 0;

   // token table
   logic       tf [80];
   logic [7:0] td [80];
   logic [2:0] tl [80];
   logic       tz [80];
   int         n_tok;

   // run observations
   logic [7:0] got_d [$];
   logic       got_l [$];
   int run_cyc, low_cnt, last_rdy, stall_seen, stall_viol;

   lzss_dec_expand dut (
      .clk              (clk),
      .rst_x            (rst_x),
      .i_valid          (i_valid),
      .ow_ready         (ow_ready),
      .i_last           (i_last),
      .i_flag           (i_flag),
      .i_data_or_offset (i_data_or_offset),
      .i_length         (i_length),
      .o_valid          (o_valid),
      .i_ready          (i_ready),
      .o_data           (o_data),
      .o_last           (o_last),
      .o_error          (o_error)
   );

   always #5 clk = ~clk;

   // capture every accepted output byte
   always @(posedge clk) begin
      if (rst_x && o_valid && i_ready) begin
         got_d.push_back(o_data);
         got_l.push_back(o_last);
      end
   end

   function automatic void add(input logic f, input logic [7:0] d, input logic [2:0] l, input logic z);
      tf[n_tok] = f; td[n_tok] = d; tl[n_tok] = l; tz[n_tok] = z;
      n_tok++;
   endfunction

   function automatic logic [7:0] gd(input int i);
      return (i < got_d.size()) ? got_d[i] : 8'hxx;
   endfunction

   function automatic logic gl(input int i);
      return (i < got_l.size()) ? got_l[i] : 1'bx;
   endfunction

   // Drive the token table; called and returns at posedge+1.
   task automatic run(input bit toggle, input int limit, input bit partial);
      int idx;
      bit held, acc;
      logic [7:0] hd;
      logic hl;
      idx = 0; held = 0; hd = '0; hl = 1'b0;
      run_cyc = 0; low_cnt = 0; last_rdy = 0; stall_seen = 0; stall_viol = 0;
      got_d.delete(); got_l.delete();
      while (1) begin
         i_ready = toggle ? ((run_cyc % 2) == 0) : 1'b1;
         if (idx < n_tok) begin
            i_valid = 1'b1; i_flag = tf[idx]; i_data_or_offset = td[idx];
            i_length = tl[idx]; i_last = tz[idx];
         end else begin
            i_valid = 1'b0; i_flag = 1'b0; i_data_or_offset = '0;
            i_length = '0; i_last = 1'b0;
         end
         @(negedge clk);
         if (!ow_ready) low_cnt++;
         if (o_valid && o_last && ow_ready) last_rdy++;
         if (held) begin
            stall_seen++;
            if (!o_valid || o_data !== hd || o_last !== hl) stall_viol++;
         end
         held = o_valid && !i_ready;
         hd = o_data; hl = o_last;
         acc = i_valid && ow_ready;
         @(posedge clk); #1;
         if (acc) idx++;
         run_cyc++;
         if (idx == n_tok && !o_valid) break;
         if (run_cyc >= limit) begin
            if (!partial) begin
               checks++; errors++;
               $display("FAIL run_timeout got %0d tokens in %0d cycles, required %0d", idx, run_cyc, n_tok);
            end
            break;
         end
      end
      i_valid = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk); rst_x = 1'b0;
      @(negedge clk); rst_x = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_x = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_last = 1'b0; i_flag = 1'b0;
      i_data_or_offset = '0; i_length = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (o_valid !== 1'b0 || o_data !== 8'h00 || o_last !== 1'b0 || o_error !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs got v=%b d=%h l=%b e=%b required 0 00 0 0", o_valid, o_data, o_last, o_error);
      end
      @(negedge clk); rst_x = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (ow_ready !== 1'b1 || o_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle got rdy=%b v=%b required 1 0", ow_ready, o_valid);
      end
   endtask

   task automatic test_literals();
      logic [7:0] ex [3];
      ex = '{8'h41, 8'h42, 8'h43};
      n_tok = 0;
      add(1'b0, 8'h41, 3'd0, 1'b0);
      add(1'b0, 8'h42, 3'd0, 1'b0);
      add(1'b0, 8'h43, 3'd0, 1'b1);
      run(1'b0, 50, 1'b0);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (gd(i) !== ex[i] || gl(i) !== (i == 2)) begin
            errors++;
            $display("FAIL lit_byte%0d got %h/%b required %h/%b", i, gd(i), gl(i), ex[i], (i == 2));
         end
      end
      checks++;
      if (run_cyc != 4 || got_d.size() != 3) begin
         errors++;
         $display("FAIL lit_timing got %0d cycles %0d bytes required 4 cycles 3 bytes", run_cyc, got_d.size());
      end
      checks++;
      if (low_cnt != 1 || last_rdy != 0) begin
         errors++;
         $display("FAIL lit_ready got low=%0d rdy_with_last=%0d required 1 0", low_cnt, last_rdy);
      end
   endtask

   task automatic test_run_length();
      n_tok = 0;
      add(1'b0, 8'h55, 3'd0, 1'b0);
      add(1'b1, 8'h00, 3'd7, 1'b0);
      run(1'b0, 50, 1'b0);
      checks++;
      if (got_d.size() != 8) begin
         errors++;
         $display("FAIL rle_count got %0d required 8", got_d.size());
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (gd(i) !== 8'h55 || gl(i) !== 1'b0) begin
            errors++;
            $display("FAIL rle_byte%0d got %h/%b required 55/0", i, gd(i), gl(i));
         end
      end
      checks++;
      if (low_cnt != 6) begin
         errors++;
         $display("FAIL rle_ready_low got %0d required 6", low_cnt);
      end
      n_tok = 0;
      add(1'b0, 8'hEE, 3'd0, 1'b1);
      run(1'b0, 20, 1'b0);
      checks++;
      if (gd(0) !== 8'hEE || gl(0) !== 1'b1) begin
         errors++;
         $display("FAIL rle_close got %h/%b required ee/1", gd(0), gl(0));
      end
   endtask

   task automatic overlap_tokens();
      n_tok = 0;
      add(1'b0, 8'h01, 3'd0, 1'b0);
      add(1'b0, 8'h02, 3'd0, 1'b0);
      add(1'b0, 8'h03, 3'd0, 1'b0);
      add(1'b1, 8'h02, 3'd5, 1'b1);
   endtask

   task automatic test_overlap();
      logic [7:0] ex [8];
      ex = '{8'h01, 8'h02, 8'h03, 8'h01, 8'h02, 8'h03, 8'h01, 8'h02};
      overlap_tokens();
      run(1'b0, 50, 1'b0);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (gd(i) !== ex[i] || gl(i) !== (i == 7)) begin
            errors++;
            $display("FAIL ovl_byte%0d got %h/%b required %h/%b", i, gd(i), gl(i), ex[i], (i == 7));
         end
      end
   endtask

   task automatic test_stall();
      logic [7:0] ex [8];
      ex = '{8'h01, 8'h02, 8'h03, 8'h01, 8'h02, 8'h03, 8'h01, 8'h02};
      overlap_tokens();
      run(1'b1, 100, 1'b0);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (gd(i) !== ex[i] || gl(i) !== (i == 7)) begin
            errors++;
            $display("FAIL stall_byte%0d got %h/%b required %h/%b", i, gd(i), gl(i), ex[i], (i == 7));
         end
      end
      checks++;
      if (stall_seen == 0 || stall_viol != 0) begin
         errors++;
         $display("FAIL stall_hold got seen=%0d viol=%0d required seen>0 viol=0", stall_seen, stall_viol);
      end
   endtask

   task automatic test_wrap();
      n_tok = 0;
      for (int i = 1; i <= 70; i++) add(1'b0, 8'(i), 3'd0, 1'b0);
      add(1'b1, 8'd63, 3'd3, 1'b1);
      run(1'b0, 200, 1'b0);
      checks++;
      if (got_d.size() != 73 || gd(69) !== 8'd70) begin
         errors++;
         $display("FAIL wrap_lits got %0d bytes last lit %h required 73 46", got_d.size(), gd(69));
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (gd(70 + i) !== 8'(7 + i) || gl(70 + i) !== (i == 2)) begin
            errors++;
            $display("FAIL wrap_copy%0d got %h/%b required %h/%b", i, gd(70 + i), gl(70 + i), 8'(7 + i), (i == 2));
         end
      end
      // after o_last the pointer restarts at 0: AA lands at 0, dist 64 reads slot 1 (literal 66)
      n_tok = 0;
      add(1'b0, 8'hAA, 3'd0, 1'b0);
      add(1'b1, 8'd63, 3'd1, 1'b1);
      run(1'b0, 20, 1'b0);
      checks++;
      if (gd(0) !== 8'hAA || gd(1) !== 8'd66 || gl(1) !== 1'b1) begin
         errors++;
         $display("FAIL wrap_restart got %h %h/%b required aa 42/1", gd(0), gd(1), gl(1));
      end
`ifndef LZSS_DEC_EXPAND_ERRCHK_EN
      checks++;
      if (o_error !== 1'b0) begin
         errors++;
         $display("FAIL error_tied got %b required 0", o_error);
      end
`endif
   endtask

   task automatic test_reset_mid_match();
      n_tok = 0;
      add(1'b0, 8'h77, 3'd0, 1'b0);
      add(1'b1, 8'h00, 3'd7, 1'b1);
      run(1'b0, 4, 1'b1);
      checks++;
      if (o_valid !== 1'b1 || o_data !== 8'h77) begin
         errors++;
         $display("FAIL mid_precond got v=%b d=%h required 1 77", o_valid, o_data);
      end
      rst_x = 1'b0;
      #1;
      checks++;
      if (o_valid !== 1'b0 || o_data !== 8'h00 || o_last !== 1'b0 || ow_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset got v=%b d=%h l=%b rdy=%b required 0 00 0 1", o_valid, o_data, o_last, ow_ready);
      end
      @(negedge clk); rst_x = 1'b1;
      @(posedge clk); #1;
      // slot 1 held 77 before reset; it must read back cleared
      n_tok = 0;
      add(1'b1, 8'd62, 3'd1, 1'b1);
      run(1'b0, 20, 1'b0);
      checks++;
      if (got_d.size() != 1 || gd(0) !== 8'h00 || gl(0) !== 1'b1) begin
         errors++;
         $display("FAIL mid_cleared got n=%0d %h/%b required 1 00/1", got_d.size(), gd(0), gl(0));
      end
   endtask

`ifdef LZSS_DEC_EXPAND_ERRCHK_EN
   task automatic test_errchk();
      pulse_reset();
      n_tok = 0;
      add(1'b1, 8'd3, 3'd1, 1'b1);
      run(1'b0, 20, 1'b0);
      checks++;
      if (o_error !== 1'b1 || gd(0) !== 8'h00) begin
         errors++;
         $display("FAIL err_set got e=%b d=%h required 1 00", o_error, gd(0));
      end
      n_tok = 0;
      add(1'b0, 8'h11, 3'd0, 1'b1);
      run(1'b0, 20, 1'b0);
      checks++;
      if (o_error !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky got %b required 1", o_error);
      end
      pulse_reset();
      checks++;
      if (o_error !== 1'b0) begin
         errors++;
         $display("FAIL err_reset got %b required 0", o_error);
      end
      n_tok = 0;
      add(1'b0, 8'h01, 3'd0, 1'b0);
      add(1'b1, 8'd0, 3'd2, 1'b1);
      run(1'b0, 20, 1'b0);
      checks++;
      if (o_error !== 1'b0 || gd(2) !== 8'h01) begin
         errors++;
         $display("FAIL err_inwindow got e=%b d=%h required 0 01", o_error, gd(2));
      end
   endtask
`endif

   initial begin
      test_reset();
      test_literals();
      test_run_length();
      test_overlap();
      test_stall();
      test_wrap();
      test_reset_mid_match();
`ifdef LZSS_DEC_EXPAND_ERRCHK_EN
      test_errchk();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
